noc_irq_scheduler: RTL and testbench
====================================

// Module: noc_irq_scheduler
// PURPOSE
//  Round-robin interrupt scheduler for the NoC input channels of the Nios system.
//  - Captures rising edges on NUM_CH request lines into sticky pending bits.
//  - Grants one pending, unmasked channel at a time and raises a single irq to the Nios.
//  - Software reads the granted channel ID, services it, then writes ACK. That write
//    releases the grant and advances the round-robin pointer.
//  - Sits on the Avalon-MM bus beside the per-channel input PIOs.
// PARAMETERS
//  NUM_CH  4  number of request channels, legal range 1..16
//  ID_W    2  localparam, clog2(NUM_CH) with a minimum of 1; width of grant ID and pointer
// PORTS
//  clk           in   1       system clock; all logic on its rising edge
//  reset         in   1       asynchronous, active-high reset
//  address       in   2       Avalon word address
//  chipselect    in   1       Avalon slave select
//  write_n       in   1       Avalon write strobe, active low
//  writedata     in   32      Avalon write data
//  readdata      out  32      Avalon read data, registered
//  req_in        in   NUM_CH  level requests from the NoC input channels, synchronous to clk
//  irq           out  1       interrupt to the Nios, registered
//  grant_onehot  out  NUM_CH  one-hot of the currently granted channel, 0 when no grant
// BEHAVIOUR
//  Reset: readdata=0, irq=0, grant_onehot=0, pending=0, mask=0, req_prev=0, ptr=0, state=IDLE.
//  Edge capture:
//   - pending[i] sets on the cycle where req_in[i]=1 and req_prev[i]=0.
//   - req_prev resets to 0, so a request already high at reset release sets pending on the first edge.
//   - If a set and a clear (W1C or ACK) hit the same bit in the same cycle, the set wins.
//  Register map (write = chipselect & ~write_n):
//   0 STATUS R   bit31=grant valid (state==ACTIVE), bits[ID_W-1:0]=grant_id, other bits 0
//   1 PEND   R/W1C  bits[NUM_CH-1:0]; writing 1 clears the bit
//   2 MASK   R/W    bits[NUM_CH-1:0]; 1 = channel enabled
//   3 ACK    W      any data; reads return 0
//  readdata is registered every cycle from address, independent of chipselect (1-cycle read latency).
//  FSM:
//   - IDLE: if |(pending & mask), the rr_arbiter picks the first set bit at or after ptr
//     (searching upward, wrapping). Latch grant_id, go to ACTIVE.
//   - ACTIVE: irq=1 and grant_onehot=1<<grant_id, both registered and valid from the cycle of entry.
//     - ACK write: clear pending[grant_id], ptr <= (grant_id==NUM_CH-1) ? 0 : grant_id+1, go to HOLD.
//     - mask[grant_id] cleared with no ACK: revoke. Go to IDLE; pending and ptr unchanged.
//     - ACK and mask-clear in the same cycle: ACK takes precedence.
//     - W1C of pending[grant_id] alone does not release the grant; only ACK or revoke does.
//   - HOLD: irq=0 for exactly one cycle, then IDLE. This guarantees an irq low gap between grants.
//  ACK written outside ACTIVE is ignored.
//  Latency: req_in rises before edge k -> pending=1 after edge k -> irq=1 after edge k+1 (if masked in and IDLE).
//  Reset asserted mid-grant: everything returns to its reset value immediately (asynchronous); pending events are lost.
//  Pointer and grant_id arithmetic is modulo NUM_CH, never modulo 2^ID_W.
// STRUCTURE
//  - Package noc_irq_pkg holds the register address constants (ADDR_STATUS=0, ADDR_PEND=1,
//    ADDR_MASK=2, ADDR_ACK=3), the STATUS valid bit index (31), and the state encoding
//    (IDLE/ACTIVE/HOLD).
//  - One sub-module, rr_arbiter: combinational, params NUM_CH/ID_W; inputs req, ptr;
//    outputs any, id. The top holds all registers and the FSM.
// TESTING
//  - Reset with req_in=4'b0000 -> readdata, irq, grant_onehot all 0; read MASK -> 0.
//  - MASK=4'hF; pulse req_in[2] -> PEND=4'b0100 one edge later; irq=1 the edge after;
//    STATUS=0x8000_0002; ACK -> irq low 1 cycle; PEND=0.
//  - MASK=4'hF, ptr=0; req_in 4'b1011 together -> grants 0,1,3 in order, one per ACK;
//    a new req[0] during grant 3 is served after 3.
//  - Ptr wrap, NUM_CH=4: grant 3, ACK -> ptr=0; pending 4'b1001 then grants 0.
//  - Revoke: channel 1 ACTIVE, write MASK=4'b1101 -> irq=0 next cycle; PEND still 4'b0010;
//    restoring mask re-grants channel 1.
//  - Corners:
//    - ACK while IDLE -> no state change.
//    - W1C of bit 2 in the same cycle as a req_in[2] rising edge -> bit stays 1.
//    - reset asserted while ACTIVE -> irq drops asynchronously.

Source files
------------

// File: rtl/noc_irq_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// noc_irq_pkg
// Shared constants for the NoC interrupt scheduler: Avalon register word
// addresses, the STATUS grant-valid bit position and the scheduler state type.
// -----------------------------------------------------------------------------
package noc_irq_pkg;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_PEND   = 2'd1;
   localparam logic [1:0] ADDR_MASK   = 2'd2;
   localparam logic [1:0] ADDR_ACK    = 2'd3;

   localparam int STATUS_VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/noc_irq_scheduler_if.sv
// -----------------------------------------------------------------------------
// noc_irq_scheduler_if
// Avalon-MM slave bus of the interrupt scheduler.
//   address    2-bit word address
//   chipselect slave select
//   write_n    write strobe, active low
//   writedata  32-bit write data
//   readdata   32-bit registered read data (driven by the slave)
// -----------------------------------------------------------------------------
interface noc_irq_scheduler_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/noc_irq_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first set bit of req at or above
// ptr, searching upward and wrapping at NUM_CH.
//   req  in  NUM_CH  candidate channels
//   ptr  in  ID_W    search start, always < NUM_CH
//   any  out 1       at least one candidate
//   id   out ID_W    chosen channel (0 when any=0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int ID_W   = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [ID_W-1:0]   ptr,
   output logic              any,
   output logic [ID_W-1:0]   id
);

   int              w_idx;
   logic [ID_W-1:0] w_sel;

   // Walk the channels starting at ptr; wrap is done modulo NUM_CH, not 2^ID_W.
   always_comb begin
      any   = 1'b0;
      id    = '0;
      w_idx = 0;
      w_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_idx = int'(ptr) + k;
         if (w_idx >= NUM_CH) begin
            w_idx = w_idx - NUM_CH;
         end
         w_sel = ID_W'(w_idx);
         if (!any && req[w_sel]) begin
            any = 1'b1;
            id  = w_sel;
         end
      end
   end

endmodule

// File: rtl/noc_irq_scheduler.sv
// -----------------------------------------------------------------------------
// noc_irq_scheduler
// Round-robin interrupt scheduler for the NoC input channels. Rising edges on
// req_in are captured into sticky pending bits; one pending, unmasked channel
// is granted at a time and signalled by irq. Software ACK releases the grant,
// advances the pointer and forces a one-cycle irq low gap.
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   bus           slave Avalon-MM register port (STATUS/PEND/MASK/ACK)
//   req_in        in   NUM_CH level requests, synchronous to clk
//   irq           out  registered interrupt, high while a grant is active
//   grant_onehot  out  registered one-hot of the granted channel, 0 if none
// -----------------------------------------------------------------------------
module noc_irq_scheduler
   import noc_irq_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   noc_irq_scheduler_if.slave   bus,
   input  logic [NUM_CH-1:0]    req_in,
   output logic                 irq,
   output logic [NUM_CH-1:0]    grant_onehot
);

   localparam int              ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CH - 1);

   function automatic logic [NUM_CH-1:0] f_onehot(input logic [ID_W-1:0] id);
      return NUM_CH'(1) << id;
   endfunction

   state_t              r_state;
   logic [NUM_CH-1:0]   r_pending;
   logic [NUM_CH-1:0]   r_mask;
   logic [NUM_CH-1:0]   r_req_prev;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_grant_id;
   logic                r_irq;
   logic [NUM_CH-1:0]   r_grant_onehot;
   logic [31:0]         r_readdata;

   state_t              w_state_nxt;
   logic [ID_W-1:0]     w_grant_id_nxt;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic                w_wr;
   logic                w_ack;
   logic [NUM_CH-1:0]   w_mask_nxt;
   logic [NUM_CH-1:0]   w_set;
   logic [NUM_CH-1:0]   w_clr;
   logic [NUM_CH-1:0]   w_pend_nxt;
   logic [NUM_CH-1:0]   w_arb_req;
   logic                w_arb_any;
   logic [ID_W-1:0]     w_arb_id;
   logic [31:0]         w_rdata;

   assign w_wr  = bus.chipselect & ~bus.write_n;
   assign w_ack = w_wr && (bus.address == ADDR_ACK) && (r_state == ACTIVE);

   assign w_mask_nxt = (w_wr && (bus.address == ADDR_MASK)) ? bus.writedata[NUM_CH-1:0] : r_mask;

   // Set has priority over both W1C and ACK clears of the same bit.
   assign w_set      = req_in & ~r_req_prev;
   assign w_clr      = ((w_wr && (bus.address == ADDR_PEND)) ? bus.writedata[NUM_CH-1:0] : '0)
                     | (w_ack ? f_onehot(r_grant_id) : '0);
   assign w_pend_nxt = (r_pending & ~w_clr) | w_set;

   assign w_arb_req  = r_pending & r_mask;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_arb (
      .req (w_arb_req),
      .ptr (r_ptr),
      .any (w_arb_any),
      .id  (w_arb_id)
   );

   // Scheduler next state. Revoke looks at the post-write mask so a MASK
   // write that disables the granted channel drops irq on that same edge.
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_id_nxt = r_grant_id;
      w_ptr_nxt      = r_ptr;
      case (r_state)
         IDLE: begin
            if (w_arb_any) begin
               w_state_nxt    = ACTIVE;
               w_grant_id_nxt = w_arb_id;
            end else begin
               w_state_nxt    = IDLE;
            end
         end
         ACTIVE: begin
            if (w_ack) begin
               w_state_nxt = HOLD;
               w_ptr_nxt   = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_W'(1);
            end else if (!w_mask_nxt[r_grant_id]) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = ACTIVE;
            end
         end
         HOLD:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Read mux, sampled every cycle regardless of chipselect.
   always_comb begin
      w_rdata = 32'd0;
      case (bus.address)
         ADDR_STATUS: begin
            w_rdata[STATUS_VALID_BIT] = (r_state == ACTIVE);
            w_rdata[ID_W-1:0]         = r_grant_id;
         end
         ADDR_PEND: w_rdata = 32'(r_pending);
         ADDR_MASK: w_rdata = 32'(r_mask);
         default:   w_rdata = 32'd0;
      endcase
   end

   // All state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_pending      <= '0;
         r_mask         <= '0;
         r_req_prev     <= '0;
         r_ptr          <= '0;
         r_grant_id     <= '0;
         r_irq          <= 1'b0;
         r_grant_onehot <= '0;
         r_readdata     <= 32'd0;
      end else begin
         r_state        <= w_state_nxt;
         r_pending      <= w_pend_nxt;
         r_mask         <= w_mask_nxt;
         r_req_prev     <= req_in;
         r_ptr          <= w_ptr_nxt;
         r_grant_id     <= w_grant_id_nxt;
         r_irq          <= (w_state_nxt == ACTIVE);
         r_grant_onehot <= (w_state_nxt == ACTIVE) ? f_onehot(w_grant_id_nxt) : '0;
         r_readdata     <= w_rdata;
      end
   end

   assign irq          = r_irq;
   assign grant_onehot = r_grant_onehot;
   assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_noc_irq_scheduler.sv
// -----------------------------------------------------------------------------
// tb_noc_irq_scheduler
// Directed bench for noc_irq_scheduler (NUM_CH=4) with a channel-level
// reference model checked on every falling clock edge, plus literal checks.
// -----------------------------------------------------------------------------
module tb_noc_irq_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_in;
   logic       irq;
   logic [3:0] grant_onehot;

   noc_irq_scheduler_if bus_if();

   noc_irq_scheduler #(.NUM_CH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus_if),
      .req_in       (req_in),
      .irq          (irq),
      .grant_onehot (grant_onehot)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   // reference model: granted channel (-1 = none), pointer, one-cycle gap flag
   logic [3:0]  m_pend = 4'd0;
   logic [3:0]  m_mask = 4'd0;
   logic [3:0]  m_prev = 4'd0;
   int          m_ptr  = 0;
   int          m_gnt  = -1;
   int          m_gid  = 0;
   bit          m_gap  = 1'b0;
   logic [31:0] m_rd   = 32'd0;

   logic        t_wr, t_ack, t_rise, t_clr;
   logic [1:0]  t_a;
   logic [31:0] t_d;
   logic [3:0]  t_mask, t_pend;
   int          t_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model update on each clock edge from the inputs seen before it
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_pend = 4'd0; m_mask = 4'd0; m_prev = 4'd0;
            m_ptr = 0; m_gnt = -1; m_gid = 0; m_gap = 1'b0; m_rd = 32'd0;
         end else begin
            t_wr = bus_if.chipselect && !bus_if.write_n;
            t_a  = bus_if.address;
            t_d  = bus_if.writedata;
            case (t_a)
               2'd0:    m_rd = ((m_gnt >= 0) ? 32'h8000_0000 : 32'h0) | 32'(m_gid);
               2'd1:    m_rd = {28'h0, m_pend};
               2'd2:    m_rd = {28'h0, m_mask};
               default: m_rd = 32'h0;
            endcase
            t_ack  = t_wr && (t_a == 2'd3) && (m_gnt >= 0);
            t_mask = (t_wr && (t_a == 2'd2)) ? t_d[3:0] : m_mask;
            for (int i = 0; i < 4; i++) begin
               t_rise = req_in[i] && !m_prev[i];
               t_clr  = (t_wr && (t_a == 2'd1) && t_d[i]) || (t_ack && (i == m_gnt));
               t_pend[i] = t_rise ? 1'b1 : (t_clr ? 1'b0 : m_pend[i]);
            end
            if (m_gnt >= 0) begin
               if (t_ack) begin
                  m_ptr = (m_gnt + 1) % 4;
                  m_gnt = -1;
                  m_gap = 1'b1;
               end else if (!t_mask[m_gnt]) begin
                  m_gnt = -1;
               end
            end else if (m_gap) begin
               m_gap = 1'b0;
            end else begin
               for (int k = 0; k < 4; k++) begin
                  t_idx = (m_ptr + k) % 4;
                  if (m_gnt < 0 && m_pend[t_idx] && m_mask[t_idx]) begin
                     m_gnt = t_idx;
                     m_gid = t_idx;
                  end
               end
            end
            m_pend = t_pend;
            m_mask = t_mask;
            m_prev = req_in;
         end
      end
   end

   // continuous comparison against the model
   always @(negedge clk) begin
      if (check_en && !reset) begin
         chk("irq", 32'(irq), 32'(m_gnt >= 0));
         chk("grant_onehot", 32'(grant_onehot), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
         chk("readdata", bus_if.readdata, m_rd);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      bus_if.address    = a;
      bus_if.writedata  = d;
      cyc();
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'd0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus_if.address = a;
      cyc();
      d = bus_if.readdata;
   endtask

   task automatic wait_grant(input string name, input logic [3:0] exp);
      int n = 0;
      while (!irq && n < 10) begin
         cyc();
         n++;
      end
      chk(name, 32'(grant_onehot), 32'(exp));
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   logic [31:0] d;

   initial begin
      reset = 1'b1;
      req_in = 4'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.address    = 2'd0;
      bus_if.writedata  = 32'd0;
      cyc();
      cyc();
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_grant", 32'(grant_onehot), 32'd0);
      chk("rst_readdata", bus_if.readdata, 32'd0);
      reset = 1'b0;
      check_en = 1'b1;

      // single request, latency and ACK gap
      rd(2'd2, d);
      chk("mask_rst", d, 32'd0);
      wr(2'd2, 32'hF);
      req_in = 4'b0100;
      cyc();
      req_in = 4'b0000;
      chk("lat_irq0", 32'(irq), 32'd0);
      rd(2'd1, d);
      chk("lat_pend", d, 32'h4);
      chk("lat_irq1", 32'(irq), 32'd1);
      chk("lat_grant", 32'(grant_onehot), 32'h4);
      rd(2'd0, d);
      chk("status", d, 32'h8000_0002);
      wr(2'd3, 32'd0);
      chk("ack_gap", 32'(irq), 32'd0);
      rd(2'd1, d);
      chk("ack_pend", d, 32'd0);

      // round robin 0,1,3 then a fresh req[0] and wrap
      pulse_reset();
      wr(2'd2, 32'hF);
      req_in = 4'b1011;
      cyc();
      req_in = 4'b0000;
      wait_grant("rr_g0", 4'b0001);
      wr(2'd3, 32'd0);
      wait_grant("rr_g1", 4'b0010);
      wr(2'd3, 32'd0);
      wait_grant("rr_g3", 4'b1000);
      req_in = 4'b0001;
      cyc();
      req_in = 4'b0000;
      chk("rr_keep3", 32'(grant_onehot), 32'h8);
      wr(2'd3, 32'd0);
      req_in = 4'b1000;
      cyc();
      req_in = 4'b0000;
      wait_grant("wrap_g0", 4'b0001);
      wr(2'd3, 32'd0);
      wait_grant("wrap_g3", 4'b1000);
      wr(2'd3, 32'd0);
      cyc();

      // revoke via mask and re-grant
      pulse_reset();
      wr(2'd2, 32'hF);
      req_in = 4'b0010;
      cyc();
      req_in = 4'b0000;
      wait_grant("rv_g1", 4'b0010);
      wr(2'd2, 32'hD);
      chk("rv_irq", 32'(irq), 32'd0);
      rd(2'd1, d);
      chk("rv_pend", d, 32'h2);
      wr(2'd2, 32'hF);
      wait_grant("rv_regrant", 4'b0010);
      wr(2'd3, 32'd0);
      cyc();
      cyc();

      // ACK while idle
      wr(2'd3, 32'd0);
      chk("ack_idle_irq", 32'(irq), 32'd0);
      cyc();

      // W1C and rising edge on the same bit in the same cycle
      wr(2'd2, 32'h0);
      req_in = 4'b0100;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      bus_if.address    = 2'd1;
      bus_if.writedata  = 32'h4;
      cyc();
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'd0;
      rd(2'd1, d);
      chk("w1c_set_wins", d, 32'h4);
      wr(2'd1, 32'h4);
      rd(2'd1, d);
      chk("w1c_clear", d, 32'h0);
      req_in = 4'b0000;

      // asynchronous reset during a grant
      wr(2'd2, 32'hF);
      req_in = 4'b0001;
      cyc();
      req_in = 4'b0000;
      wait_grant("ar_g0", 4'b0001);
      #1;
      reset = 1'b1;
      #1;
      chk("ar_irq", 32'(irq), 32'd0);
      chk("ar_grant", 32'(grant_onehot), 32'd0);
      cyc();
      reset = 1'b0;
      cyc();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
